// File: rtl/video_bus_pkg.sv
// Shared definitions for blocks that talk to the PPU register bus:
// register indices and the OAM DMA sequencer states.
package video_bus_pkg;

    localparam logic [2:0] PPUCTRL   = 3'd0;
    localparam logic [2:0] PPUMASK   = 3'd1;
    localparam logic [2:0] PPUSTATUS = 3'd2;
    localparam logic [2:0] OAMADDR   = 3'd3;
    localparam logic [2:0] OAMDATA   = 3'd4;
    localparam logic [2:0] PPUSCROLL = 3'd5;
    localparam logic [2:0] PPUADDR   = 3'd6;
    localparam logic [2:0] PPUDATA   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies one source page into the PPU OAMDATA register,
// one read tick plus one write tick per byte, paced by the CPU-cycle enable.
module oam_dma
    import video_bus_pkg::*;
#(
    parameter logic [2:0] P_reg_addr = OAMDATA,
    parameter int          P_length   = 256
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_tick,
    input  logic        I_odd,
    input  logic        I_start,
    input  logic [7:0]  I_page,
    output logic        O_busy,
    output logic        O_done,
    output logic [15:0] O_mem_addr,
    output logic        O_mem_rden,
    input  logic [7:0]  I_mem_data,
    output logic [2:0]  O_host_addr,
    output logic        O_host_wren,
    output logic        O_host_rden,
    output logic [7:0]  O_host_data
);

    localparam logic [7:0] LAST_INDEX = 8'(P_length - 1);

    dma_state_t  state_reg, state_next;
    logic [7:0]  index_reg, index_next;
    logic [7:0]  page_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [15:0] mem_addr_reg;
    logic        mem_rden_reg;
    logic        host_wren_reg;
    logic [7:0]  host_data_reg;
    logic        last_byte;

    assign last_byte = (index_reg == LAST_INDEX);

    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        unique case (state_reg)
            ST_IDLE: begin
                // The start strobe is a single clock wide, so it is taken
                // whether or not this clock carries a CPU tick.
                if (I_start) begin
                    state_next = ST_HALT;
                    index_next = 8'd0;
                end
            end
            ST_HALT: begin
                if (I_tick) state_next = I_odd ? ST_ALIGN : ST_READ;
            end
            ST_ALIGN: begin
                if (I_tick) state_next = ST_READ;
            end
            ST_READ: begin
                if (I_tick) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (I_tick) begin
                    if (last_byte) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_READ;
                        index_next = index_reg + 8'd1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            index_reg <= 8'd0;
        end else begin
            index_reg <= index_next;
        end
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe and hold across clocks without a tick.
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            page_reg      <= 8'd0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            mem_addr_reg  <= 16'd0;
            mem_rden_reg  <= 1'b0;
            host_wren_reg <= 1'b0;
            host_data_reg <= 8'd0;
        end else begin
            busy_reg      <= (state_next != ST_IDLE);
            done_reg      <= (state_reg == ST_WRITE) && I_tick && last_byte;
            mem_rden_reg  <= (state_next == ST_READ);
            host_wren_reg <= (state_next == ST_WRITE);
            if (state_reg == ST_IDLE && I_start) begin
                page_reg <= I_page;
            end
            if (state_next == ST_READ && state_reg != ST_READ) begin
                mem_addr_reg <= {page_reg, index_next};
            end
            if (state_reg == ST_READ && I_tick) begin
                host_data_reg <= I_mem_data;
            end
        end
    end

    assign O_busy      = busy_reg;
    assign O_done      = done_reg;
    assign O_mem_addr  = mem_addr_reg;
    assign O_mem_rden  = mem_rden_reg;
    assign O_host_addr = P_reg_addr;
    assign O_host_wren = host_wren_reg;
    assign O_host_rden = 1'b0;
    assign O_host_data = host_data_reg;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: a scoreboard of expected (address, byte) pairs
// is filled at each start and drained on every rising edge of the PPU write.
module tb_oam_dma;
    import video_bus_pkg::*;

    logic        clk = 1'b0;
    logic        I_reset, I_tick, I_odd, I_start;
    logic [7:0]  I_page, I_mem_data;
    logic        O_busy, O_done, O_mem_rden, O_host_wren, O_host_rden;
    logic [15:0] O_mem_addr;
    logic [2:0]  O_host_addr;
    logic [7:0]  O_host_data;

    always #5 clk = ~clk;

    oam_dma #(.P_reg_addr(OAMDATA), .P_length(256)) dut (
        .I_clock(clk),
        .I_reset(I_reset),
        .I_tick(I_tick),
        .I_odd(I_odd),
        .I_start(I_start),
        .I_page(I_page),
        .O_busy(O_busy),
        .O_done(O_done),
        .O_mem_addr(O_mem_addr),
        .O_mem_rden(O_mem_rden),
        .I_mem_data(I_mem_data),
        .O_host_addr(O_host_addr),
        .O_host_wren(O_host_wren),
        .O_host_rden(O_host_rden),
        .O_host_data(O_host_data)
    );

    // Source memory: page 0x02 holds i ^ 0xA5; other pages are also mixed
    // with their page number so a wrong page shows up as wrong data.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ 8'hA5 ^ (a[15:8] - 8'h02);
    endfunction

    assign I_mem_data = mem_byte(O_mem_addr);

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } sb_t;

    sb_t         sb_q[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          tick_div   = 1;
    int          phase      = 0;
    int          busy_ticks, writes, done_cnt, first_rden_tick, bad_pulse;
    int          wren_len, gap_len;
    logic        rden_prev = 1'b0, wren_prev = 1'b0, done_prev = 1'b0;
    logic [15:0] rd_addr = 16'd0, last_addr = 16'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        busy_ticks      = 0;
        writes          = 0;
        done_cnt        = 0;
        first_rden_tick = -1;
        bad_pulse       = 0;
        wren_len        = 0;
        gap_len         = 0;
    endtask

    task automatic fill_sb(input logic [7:0] page);
        logic [15:0] a;
        sb_q.delete();
        for (int i = 0; i < 256; i++) begin
            a = {page, 8'(i)};
            sb_q.push_back('{addr: a, data: mem_byte(a)});
        end
    endtask

    // One clock: drive the tick, take the edge, then observe the outputs.
    task automatic cycle();
        logic tick_now, busy_pre;
        sb_t  exp_e;
        I_tick   = (phase == 0);
        phase    = (phase + 1 >= tick_div) ? 0 : phase + 1;
        tick_now = I_tick;
        busy_pre = O_busy;
        @(posedge clk);
        #1;
        if (tick_now && busy_pre) busy_ticks++;
        if (O_mem_rden && !rden_prev) begin
            rd_addr   = O_mem_addr;
            last_addr = O_mem_addr;
            if (first_rden_tick < 0) first_rden_tick = busy_ticks + 1;
        end
        if (O_host_wren) begin
            if (!wren_prev) begin
                writes++;
                if (writes > 1 && gap_len < tick_div) bad_pulse++;
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'(writes), 32'd0);
                end else begin
                    exp_e = sb_q.pop_front();
                    check("ppu_write", {8'h00, rd_addr, O_host_data},
                          {8'h00, exp_e.addr, exp_e.data});
                end
                wren_len = 0;
            end
            wren_len++;
        end else begin
            if (wren_prev) begin
                if (wren_len != tick_div) bad_pulse++;
                gap_len = 0;
            end
            gap_len++;
        end
        if (O_done) begin
            done_cnt++;
            if (done_prev) bad_pulse++;
        end
        rden_prev = O_mem_rden;
        wren_prev = O_host_wren;
        done_prev = O_done;
    endtask

    task automatic run_xfer(input string name, input logic [7:0] page, input logic odd,
                            input int div, input int restart_tick, input bit end_start);
        int n;
        bit restarted;
        clear_stats();
        tick_div = div;
        phase    = 0;
        fill_sb(page);
        I_odd   = odd;
        I_page  = page;
        I_start = 1'b1;
        cycle();
        I_start   = 1'b0;
        restarted = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 520 * div + 20) begin
            if (restart_tick > 0 && !restarted && busy_ticks >= restart_tick) begin
                I_start   = 1'b1;
                I_page    = 8'h07;
                restarted = 1'b1;
            end
            if (end_start && writes == 256 && O_host_wren) I_start = 1'b1;
            cycle();
            I_start = 1'b0;
            I_page  = page;
            n++;
        end
        check({name, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (4) cycle();
        check({name, "_writes"}, 32'(writes), 32'd256);
        check({name, "_busy_ticks"}, 32'(busy_ticks), 32'(513 + int'(odd)));
        check({name, "_done_count"}, 32'(done_cnt), 32'd1);
        check({name, "_first_rden_tick"}, 32'(first_rden_tick), 32'(2 + int'(odd)));
        check({name, "_sb_left"}, 32'(sb_q.size()), 32'd0);
        check({name, "_pulse_shape"}, 32'(bad_pulse), 32'd0);
        check({name, "_busy_after"}, 32'(O_busy), 32'd0);
        check({name, "_last_addr"}, 32'(last_addr), 32'({page, 8'hFF}));
        $display("xfer %s page=%02h odd=%0d div=%0d writes=%0d busy_ticks=%0d done=%0d last=%04h",
                 name, page, odd, div, writes, busy_ticks, done_cnt, last_addr);
    endtask

    initial begin
        int n;
        I_reset = 1'b1;
        I_tick  = 1'b0;
        I_odd   = 1'b0;
        I_start = 1'b0;
        I_page  = 8'h00;
        clear_stats();
        repeat (2) cycle();
        // Start during reset must lose to reset.
        I_start = 1'b1;
        I_page  = 8'h33;
        cycle();
        I_start = 1'b0;
        check("rst_busy", 32'(O_busy), 32'd0);
        check("rst_done", 32'(O_done), 32'd0);
        check("rst_rden", 32'(O_mem_rden), 32'd0);
        check("rst_wren", 32'(O_host_wren), 32'd0);
        check("rst_host_rden", 32'(O_host_rden), 32'd0);
        check("rst_mem_addr", 32'(O_mem_addr), 32'd0);
        check("rst_host_data", 32'(O_host_data), 32'd0);
        check("rst_host_addr", 32'(O_host_addr), 32'd4);
        I_reset = 1'b0;
        cycle();
        check("rst_no_start", 32'(O_busy), 32'd0);
        $display("reset outputs busy=%0d wren=%0d addr=%04h host_addr=%0d",
                 O_busy, O_host_wren, O_mem_addr, O_host_addr);

        run_xfer("even", 8'h02, 1'b0, 1, 0, 1'b0);
        run_xfer("odd", 8'h02, 1'b1, 1, 0, 1'b0);
        run_xfer("div3", 8'h02, 1'b0, 3, 0, 1'b0);
        run_xfer("restart", 8'h02, 1'b0, 1, 100, 1'b1);

        // Abort with reset while byte 37 is in its write tick.
        clear_stats();
        tick_div = 1;
        phase    = 0;
        fill_sb(8'h02);
        I_odd   = 1'b0;
        I_page  = 8'h02;
        I_start = 1'b1;
        cycle();
        I_start = 1'b0;
        n = 0;
        while (!(writes == 38 && O_host_wren) && n < 200) begin
            cycle();
            n++;
        end
        check("abort_reached", 32'(writes), 32'd38);
        I_reset = 1'b1;
        cycle();
        I_reset = 1'b0;
        check("abort_busy", 32'(O_busy), 32'd0);
        check("abort_done", 32'(O_done), 32'd0);
        check("abort_rden", 32'(O_mem_rden), 32'd0);
        check("abort_wren", 32'(O_host_wren), 32'd0);
        check("abort_mem_addr", 32'(O_mem_addr), 32'd0);
        check("abort_host_data", 32'(O_host_data), 32'd0);
        repeat (5) cycle();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_idle", 32'(O_busy), 32'd0);
        $display("abort writes=%0d done=%0d busy=%0d", writes, done_cnt, O_busy);

        run_xfer("after_reset", 8'h02, 1'b0, 1, 0, 1'b0);
        run_xfer("page_ff", 8'hFF, 1'b0, 1, 0, 1'b0);
        check("final_host_addr", 32'(O_host_addr), 32'd4);
        check("final_host_rden", 32'(O_host_rden), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 P_reg_addr, 3'd4, PPU register index written for each byte (OAMDATA).
REQ-002 P_length, 256, bytes per transfer; must be a power of two, at most 256.
REQ-003 I_clock  input  1  system clock; the only clock; all state changes on its rising edge.
REQ-004 I_reset  input  1  reset; synchronous and active-high.
REQ-005 I_tick  input  1  CPU-cycle enable; the state machine advances only on clocks where I_tick=1.
REQ-006 I_odd  input  1  CPU cycle parity; 1 = current CPU cycle is odd.
REQ-007 I_start  input  1  single-clock start strobe (CPU write to the DMA page register).
REQ-008 I_page  input  8  source page; sampled with I_start.
REQ-009 O_busy  output  1  transfer in progress; halts the CPU.
REQ-010 O_done  output  1  one-clock pulse when a transfer completes.
REQ-011 O_mem_addr  output  16  source address {page, index}.
REQ-012 O_mem_rden  output  1  source read strobe.
REQ-013 I_mem_data  input  8  source read data; valid on the clock O_mem_rden is high.
REQ-014 O_host_addr  output  3  PPU register index; always P_reg_addr.
REQ-015 O_host_wren  output  1  PPU write level; the PPU edge-detects its rising edge.
REQ-016 O_host_rden  output  1  PPU read level; constantly 0.
REQ-017 O_host_data  output  8  byte written to the PPU.

Function
REQ-018 All outputs are registered; none is combinational from an input.
REQ-019 States: IDLE, HALT, ALIGN, READ, WRITE.
REQ-020 IDLE: on I_start=1, latch I_page, clear index to 0, and go to HALT on the next clock regardless of I_tick.
REQ-021 HALT: on a tick, go to ALIGN if I_odd=1, else go to READ.
REQ-022 ALIGN: on a tick, go to READ.
REQ-023 READ: on a tick, O_mem_rden=1 with O_mem_addr={page, index}; I_mem_data is captured into O_host_data; next state is WRITE.
REQ-024 WRITE: O_host_wren=1 for exactly this one tick; then go to READ with index+1, or, when index=P_length-1, go to IDLE.
REQ-025 O_host_wren is 0 in every state except WRITE, so each byte produces a distinct rising edge.
REQ-026 O_mem_rden is asserted for the tick duration of READ only.
REQ-027 Index is 8 bits and wraps; the address never carries into the page byte.
REQ-028 O_busy=1 from the clock after I_start through the last WRITE tick.
REQ-029 O_done pulses for one clock on the WRITE-to-IDLE transition.
REQ-030 Transfer length is 1+(odd?1:0)+2*P_length ticks: 513 or 514 for 256 bytes.
REQ-031 I_start while busy is ignored; I_page is not re-latched.
REQ-032 I_start coincident with the completion clock is ignored.
REQ-033 Clocks with I_tick=0 hold the state and outputs, except that strobe outputs stay asserted until the next tick.

Reset
REQ-034 I_reset=1 forces IDLE, index=0, page=0.
REQ-035 I_reset=1 forces O_busy, O_done, O_mem_rden, O_host_wren and O_host_rden to 0.
REQ-036 I_reset=1 forces O_mem_addr=0 and O_host_data=0.
REQ-037 O_host_addr is forced to P_reg_addr at all times, including reset.
REQ-038 Reset mid-transfer aborts the transfer without an O_done pulse.
REQ-039 Reset has priority over I_start.

Structure
REQ-040 The state enum and the register-index constants (OAMDATA=4 etc.) are placed in a shared package, video_bus_pkg.
REQ-041 There are no sub-modules; the tick-gated state machine is a single always block with a separate index counter.

Verification
REQ-042 Start with page=0x02, I_odd=0, I_tick every clock, memory[0x0200+i]=i ^ 0xA5: expect 256 PPU writes in order, 513 busy ticks, then one O_done.
REQ-043 Same start with I_odd=1 at HALT: expect 514 busy ticks, and the first O_mem_rden at tick 3 rather than tick 2.
REQ-044 I_tick=1 every third clock: expect each O_host_wren high exactly one tick period and low at least one tick between writes; the PPU edge detector sees 256 rises.
REQ-045 I_start with page=0x07 at tick 100 of a page-0x02 transfer: expect no restart, all addresses in 0x02xx, and a single O_done.
REQ-046 Reset at byte 37 (WRITE state): expect all outputs 0 on the next clock, no O_done, and a fresh start afterwards beginning at index 0.
REQ-047 Page=0xFF: expect the last address to be 0xFFFF with no wrap into page 0x00 beyond it.
